// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants: instruction/address widths, reset PC and fetch stride.
package cpu_pkg;
   localparam int          INST_W      = 32;
   localparam int          ADDR_W      = 32;
   localparam logic [31:0] RESET_PC    = 32'h0000_0000;
   localparam logic [31:0] NOP_INST    = 32'hE1A0_0000; // mov r0,r0
   localparam int          WORD_STRIDE = 4;
endpackage

// File: rtl/inst_fifo.sv
// Circular buffer of fetched {instruction, pc} words; registered head, no bypass.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module inst_fifo
   import cpu_pkg::*;
#(
   parameter int  DEPTH = 2,
   parameter int  W     = INST_W + ADDR_W,
   localparam int AW    = $clog2(DEPTH)
)(
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic          flush_i,
   input  logic [W-1:0]  wdata_i,
   output logic [W-1:0]  rdata_o,
   output logic [AW:0]   count_o,
   output logic          full_o,
   output logic          empty_o
);
   logic [W-1:0] r_mem [DEPTH];
   logic [AW:0]  r_wr_ptr;
   logic [AW:0]  r_rd_ptr;

   assign count_o = r_wr_ptr - r_rd_ptr;
   assign empty_o = (r_wr_ptr == r_rd_ptr);
   assign full_o  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   // Empty head reads as zero so stale entries never leak onto the outputs.
   assign rdata_o = empty_o ? '0 : r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk_i) begin
      if (reset_i || flush_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (push_i && (!full_o || pop_i)) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wdata_i;
            r_wr_ptr                <= r_wr_ptr + 1'b1;
         end
         if (pop_i && !empty_o)
            r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end
endmodule

// File: rtl/inst_prefetch.sv
// Fetch front end: PC generation, 1-cycle imem port, tagged instruction FIFO to decode.
// A taken branch flushes the FIFO, kills the in-flight response and refetches from the target.
module inst_prefetch #(
   parameter int                DEPTH    = 2,
   parameter int                ADDR_W   = cpu_pkg::ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(cpu_pkg::RESET_PC)
)(
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              branch_i,
   input  logic [ADDR_W-1:0] branch_target_i,
   output logic              imem_req_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   input  logic [31:0]       imem_data_i,
   output logic              inst_valid_o,
   input  logic              inst_ready_i,
   output logic [31:0]       inst_o,
   output logic [ADDR_W-1:0] inst_pc_o
);
   import cpu_pkg::*;

   localparam int CW = $clog2(DEPTH);

   logic [ADDR_W-1:0]        r_pc;
   logic [ADDR_W-1:0]        r_req_addr;
   logic                     r_inflight;
   logic                     r_kill;
   logic                     w_pop;
   logic                     w_push;
   logic                     w_empty;
   logic                     w_full;
   logic [CW:0]              w_count;
   logic [CW+1:0]            w_occ;
   logic [INST_W+ADDR_W-1:0] w_rdata;
   logic                     w_unused_tgt;

   assign w_unused_tgt = ^branch_target_i[1:0];

   assign inst_valid_o = !w_empty;
   assign w_pop        = inst_valid_o && inst_ready_i && !branch_i && !reset_i;

   // Entries buffered plus the one in flight, net of this cycle's pop, must stay below DEPTH.
   assign w_occ        = {1'b0, w_count} + (CW+2)'(r_inflight) - (CW+2)'(w_pop);
   assign imem_req_o   = !reset_i && !branch_i && (w_occ < (CW+2)'(DEPTH));
   assign imem_addr_o  = r_pc;

   assign w_push = r_inflight && !r_kill && !branch_i && !reset_i && (!w_full || w_pop);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_pc       <= RESET_PC;
         r_req_addr <= '0;
         r_inflight <= 1'b0;
         r_kill     <= 1'b0;
      end else begin
         r_inflight <= imem_req_o;
         r_kill     <= branch_i;
         r_req_addr <= r_pc;
         if (branch_i)
            r_pc <= {branch_target_i[ADDR_W-1:2], 2'b00};
         else if (imem_req_o)
            r_pc <= r_pc + ADDR_W'(WORD_STRIDE);
      end
   end

   inst_fifo #(
      .DEPTH (DEPTH),
      .W     (INST_W + ADDR_W)
   ) u_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .push_i  (w_push),
      .pop_i   (w_pop),
      .flush_i (branch_i),
      .wdata_i ({imem_data_i, r_req_addr}),
      .rdata_o (w_rdata),
      .count_o (w_count),
      .full_o  (w_full),
      .empty_o (w_empty)
   );

   assign inst_o    = w_rdata[INST_W+ADDR_W-1:ADDR_W];
   assign inst_pc_o = w_rdata[ADDR_W-1:0];
endmodule
